// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: idle patterns,
// digit-code width and the hex glyph table.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int CODE_W     = 5;

  localparam logic [5:0] AN_OFF  = 6'h3F;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_mux6_if.sv
// Digit-code inputs and scanned anode/segment outputs of the 6-digit multiplexer.
interface seg7_mux6_if;
  import seg7_pkg::*;

  logic [CODE_W-1:0] in0, in1, in2, in3, in4, in5;
  logic [5:0]        an;
  logic [7:0]        seg;
  logic              frame_tick;

  modport master (output in0, in1, in2, in3, in4, in5,
                  input  an, seg, frame_tick);
  modport slave  (input  in0, in1, in2, in3, in4, in5,
                  output an, seg, frame_tick);
endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex + decimal-point to active-low {dp,g,f,e,d,c,b,a} decoder.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, SEG_PAT[hex]};

endmodule

// File: rtl/seg7_mux6.sv
// Six-digit time-multiplexed seven-segment driver with per-slot blanking and
// frame-synchronous capture of the digit codes.
module seg7_mux6
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
)(
  input  logic clk,
  input  logic rst_n,
  seg7_mux6_if.slave bus
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0]     slot_cnt;
  logic [2:0]        idx;
  logic [CODE_W-1:0] shadow [NUM_DIGITS];
  logic [CODE_W-1:0] live   [NUM_DIGITS];
  logic [CODE_W-1:0] cur_code;
  logic [7:0]        dec_seg;
  logic [5:0]        an_next;
  logic              frame_start;
  logic              blank;

  always_comb begin
    live[0] = bus.in0;
    live[1] = bus.in1;
    live[2] = bus.in2;
    live[3] = bus.in3;
    live[4] = bus.in4;
    live[5] = bus.in5;
  end

  assign frame_start = (slot_cnt == '0) && (idx == 3'd0);
  assign blank       = 32'(slot_cnt) < 32'(BLANK_CYCLES);
  assign an_next     = ~(6'b000001 << idx);

  // Digit 0 is being captured on the same edge it is first shown (matters
  // when blanking is disabled), so bypass the shadow register for it.
  always_comb begin
    cur_code = shadow[0];
    case (idx)
      3'd0:    cur_code = frame_start ? live[0] : shadow[0];
      3'd1:    cur_code = shadow[1];
      3'd2:    cur_code = shadow[2];
      3'd3:    cur_code = shadow[3];
      3'd4:    cur_code = shadow[4];
      3'd5:    cur_code = shadow[5];
      default: cur_code = shadow[0];
    endcase
  end

  hex_to_seg u_dec (
    .hex (cur_code[3:0]),
    .dp  (cur_code[4]),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt       <= '0;
      idx            <= 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      if (slot_cnt == CNT_LAST) begin
        slot_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
      if (frame_start) begin
        for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= live[i];
      end
      bus.frame_tick <= frame_start;
      bus.an         <= blank ? AN_OFF  : an_next;
      bus.seg        <= blank ? SEG_OFF : dec_seg;
    end
  end

endmodule

// File: tb/tb_seg7_mux6.sv
// Scoreboard bench for seg7_mux6: three builds (blank 1, 0, 4) scanned side by side.
module tb_seg7_mux6;

  typedef struct packed {
    logic [5:0] an0; logic [7:0] seg0; logic t0;
    logic [5:0] an1; logic [7:0] seg1; logic t1;
    logic [5:0] an2; logic [7:0] seg2; logic t2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] in_r [6];
  logic [6:0] hex_tab [16];
  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       q [$];
  exp_t       exp_v = '0;
  exp_t       obs;

  always #5 clk = ~clk;

  seg7_mux6_if i0 ();
  seg7_mux6_if i1 ();
  seg7_mux6_if i2 ();

  assign {i0.in5, i0.in4, i0.in3, i0.in2, i0.in1, i0.in0} = {in_r[5], in_r[4], in_r[3], in_r[2], in_r[1], in_r[0]};
  assign {i1.in5, i1.in4, i1.in3, i1.in2, i1.in1, i1.in0} = {in_r[5], in_r[4], in_r[3], in_r[2], in_r[1], in_r[0]};
  assign {i2.in5, i2.in4, i2.in3, i2.in2, i2.in1, i2.in0} = {in_r[5], in_r[4], in_r[3], in_r[2], in_r[1], in_r[0]};

  seg7_mux6 #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut    (.clk(clk), .rst_n(rst_n), .bus(i0));
  seg7_mux6 #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(i1));
  seg7_mux6 #(.DIGIT_CYCLES(4), .BLANK_CYCLES(4)) dut_dk (.clk(clk), .rst_n(rst_n), .bus(i2));

  assign obs = {i0.an, i0.seg, i0.frame_tick, i1.an, i1.seg, i1.frame_tick, i2.an, i2.seg, i2.frame_tick};

  // Reference: k counts edges since frame start; 24-clock frame, 4-clock slots.
  int         k = 0;
  logic [4:0] m_sh [6];
  always @(posedge clk) begin : model
    exp_t       e;
    int         pos, dg, c;
    logic [4:0] code;
    logic [7:0] lit;
    if (rst_n !== 1'b1) begin
      k = 0;
      for (int i = 0; i < 6; i++) m_sh[i] = 5'h00;
      e = {6'h3F, 8'hFF, 1'b0, 6'h3F, 8'hFF, 1'b0, 6'h3F, 8'hFF, 1'b0};
    end else begin
      pos = k % 24;
      dg  = pos / 4;
      c   = pos % 4;
      if (pos == 0) for (int i = 0; i < 6; i++) m_sh[i] = in_r[i];
      code   = m_sh[dg];
      lit    = {~code[4], hex_tab[code[3:0]]};
      e.t0   = (pos == 0);
      e.t1   = (pos == 0);
      e.t2   = (pos == 0);
      e.an0  = (c < 1) ? 6'h3F : ~(6'd1 << dg);
      e.seg0 = (c < 1) ? 8'hFF : lit;
      e.an1  = ~(6'd1 << dg);
      e.seg1 = lit;
      e.an2  = 6'h3F;
      e.seg2 = 8'hFF;
      k++;
    end
    q.push_back(e);
  end

  always @(negedge clk) if (q.size() > 0) exp_v = q.pop_front();

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (i0.frame_tick !== 1'b1 && n < 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) in_r[i] = 5'h10 + 5'(i);
    for (int j = 0; j < 3; j++) begin
      step();
      n_chk++;
      if (i0.an !== 6'h3F || i0.seg !== 8'hFF || i0.frame_tick !== 1'b0 || obs !== exp_v)
        $display("FAIL reset_hold cyc%0d: got %h want an=3f seg=ff tick=0 (%h)", j, obs, exp_v);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 48; j++) begin
      step();
      n_chk++;
      if (obs !== exp_v) $display("FAIL reset_scan cyc%0d: got %h want %h", j, obs, exp_v);
      else n_pass++;
      if (j == 0 || j == 24) begin
        n_chk++;
        if (i0.frame_tick !== 1'b1 || i0.an !== 6'h3F)
          $display("FAIL reset_tick cyc%0d: got tick=%b an=%h want tick=1 an=3f", j, i0.frame_tick, i0.an);
        else n_pass++;
      end
      if (j >= 1 && j <= 3) begin
        n_chk++;
        if (i0.an !== 6'h3E || i0.seg !== 8'h40)
          $display("FAIL reset_dig0 cyc%0d: got an=%h seg=%h want an=3e seg=40", j, i0.an, i0.seg);
        else n_pass++;
      end
      if (j == 5) begin
        n_chk++;
        if (i0.an !== 6'h3D || i0.seg !== 8'h79)
          $display("FAIL reset_dig1: got an=%h seg=%h want an=3d seg=79", i0.an, i0.seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_no_tearing();
    for (int i = 0; i < 6; i++) in_r[i] = 5'(i);
    sync_frame();
    n_chk++;
    if (i0.frame_tick !== 1'b1) $display("FAIL tear_sync: got tick=%b want 1", i0.frame_tick);
    else n_pass++;
    for (int p = 1; p < 48; p++) begin
      step();
      n_chk++;
      if (obs !== exp_v) $display("FAIL tear_scan pos%0d: got %h want %h", p, obs, exp_v);
      else n_pass++;
      if (p == 13) in_r[1] = 5'h08;
      if (p == 5 || p == 29) begin
        n_chk++;
        if (i0.an !== 6'h3D || i0.seg !== ((p == 5) ? 8'hF9 : 8'h80))
          $display("FAIL tear_dig1 pos%0d: got an=%h seg=%h want an=3d seg=%h", p, i0.an, i0.seg,
                   (p == 5) ? 8'hF9 : 8'h80);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hex_all();
    for (int h = 0; h < 16; h++) begin
      logic [3:0] hv;
      logic       dp;
      logic [7:0] want;
      hv   = 4'(h);
      dp   = h[0];
      want = {~dp, hex_tab[hv]};
      in_r[0] = {dp, hv};
      sync_frame();
      n_chk++;
      if (i0.frame_tick !== 1'b1 || i1.an !== 6'h3E || i1.seg !== want)
        $display("FAIL hex_nb h%0d: got tick=%b an=%h seg=%h want tick=1 an=3e seg=%h", h, i0.frame_tick, i1.an, i1.seg, want);
      else n_pass++;
      step();
      n_chk++;
      if (i0.an !== 6'h3E || i0.seg !== want || obs !== exp_v)
        $display("FAIL hex_dig0 h%0d: got an=%h seg=%h want an=3e seg=%h", h, i0.an, i0.seg, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    sync_frame();
    for (int p = 1; p <= 17; p++) step();
    n_chk++;
    if (i0.an !== 6'h2F) $display("FAIL mid_pre: got an=%h want 2f", i0.an);
    else n_pass++;
    in_r[0] = 5'h0C;
    rst_n = 1'b0;
    step();
    n_chk++;
    if (i0.an !== 6'h3F || i0.seg !== 8'hFF || i0.frame_tick !== 1'b0 ||
        i1.an !== 6'h3F || i1.seg !== 8'hFF || obs !== exp_v)
      $display("FAIL mid_reset: got %h want an=3f seg=ff tick=0 on all", obs);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_chk++;
    if (i0.frame_tick !== 1'b1 || i0.an !== 6'h3F || i1.an !== 6'h3E || i1.seg !== 8'hC6)
      $display("FAIL mid_restart: got tick=%b an=%h nb_an=%h nb_seg=%h want 1 3f 3e c6",
               i0.frame_tick, i0.an, i1.an, i1.seg);
    else n_pass++;
    for (int p = 1; p < 24; p++) begin
      step();
      n_chk++;
      if (obs !== exp_v || (p == 1 && (i0.an !== 6'h3E || i0.seg !== 8'hC6)))
        $display("FAIL mid_scan pos%0d: got %h want %h", p, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_blank_variants();
    sync_frame();
    for (int p = 0; p < 48; p++) begin
      if (p > 0) step();
      n_chk++;
      if ($countones(~i1.an) != 1) $display("FAIL nb_onecold pos%0d: got an=%h want one low bit", p, i1.an);
      else n_pass++;
      n_chk++;
      if (i2.an !== 6'h3F || i2.seg !== 8'hFF || i2.frame_tick !== (p % 24 == 0))
        $display("FAIL dark pos%0d: got an=%h seg=%h tick=%b want 3f ff %b", p, i2.an, i2.seg, i2.frame_tick, p % 24 == 0);
      else n_pass++;
    end
  endtask

  task automatic test_frames();
    int cnt [6];
    sync_frame();
    for (int f = 0; f < 10; f++) begin
      for (int d = 0; d < 6; d++) cnt[d] = 0;
      for (int p = 0; p < 24; p++) begin
        if (p > 0 || f > 0) step();
        for (int d = 0; d < 6; d++) if (i0.an[d] === 1'b0) cnt[d]++;
        n_chk++;
        if ($countones(~i0.an) > 1 || i0.frame_tick !== (p == 0) || obs !== exp_v)
          $display("FAIL frame%0d pos%0d: got %h want %h", f, p, obs, exp_v);
        else n_pass++;
      end
      for (int d = 0; d < 6; d++) begin
        n_chk++;
        if (cnt[d] != 3) $display("FAIL frame%0d_an%0d: got %0d low clocks want 3", f, d, cnt[d]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset();
    test_no_tearing();
    test_hex_all();
    test_reset_mid();
    test_blank_variants();
    test_frames();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_mux6.md
SEG7_MUX6 -- requirements
Module: seg7_mux6

Interface
REQ-001 The block SHALL have parameter DIGIT_CYCLES, default 100000, meaning clocks per digit slot (1 kHz slot at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, meaning clocks at the start of each slot with all anodes off (anti-ghosting).
REQ-003 The block SHALL have port clk  input  1  system clock, 100 MHz, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports in0..in5  input  5 each  digit codes (in0 rightmost): bit4 = decimal point on, bits3:0 = hex value.
REQ-006 The block SHALL have port an  output  6  digit anodes, active-low, an[i] drives digit i.
REQ-007 The block SHALL have port seg  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port frame_tick  output  1  one-clock pulse at the start of each 6-digit frame.

Function
REQ-009 A slot counter SHALL count 0..DIGIT_CYCLES-1 and wrap; at wrap the digit index SHALL advance 0->1->2->3->4->5->0.
REQ-010 A frame SHALL be 6*DIGIT_CYCLES clocks; frame start = slot counter 0 with index 0.
REQ-011 At frame start the block SHALL capture in0..in5 into shadow registers; input changes mid-frame SHALL NOT affect the display until the next frame (no tearing).
REQ-012 an, seg and frame_tick SHALL be registered, each lagging the counter/index state by exactly 1 clock.
REQ-013 When slot counter < BLANK_CYCLES, an SHALL be 6'h3F and seg SHALL be 8'hFF.
REQ-014 Otherwise an SHALL have only bit[index] low and seg SHALL be the decode of shadow[index].
REQ-015 The decode SHALL map hex 0..F (abcdefg lit, active-low) to {gfedcba}: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E; seg[7] = ~bit4.
REQ-016 frame_tick SHALL be 1 for exactly one clock per frame, aligned with the output cycle of slot 0 counter 0 of digit 0.
REQ-017 BLANK_CYCLES = 0 SHALL be legal (no blanking); BLANK_CYCLES >= DIGIT_CYCLES SHALL leave the display permanently dark (an = 3F) while counters and frame_tick run normally.
REQ-018 DIGIT_CYCLES = 1 SHALL be legal; counter width SHALL be clog2 of DIGIT_CYCLES, minimum 1 bit.

Reset
REQ-019 While rst_n = 0 at a rising edge: slot counter = 0, index = 0, shadow = 0, an = 6'h3F, seg = 8'hFF, frame_tick = 0.
REQ-020 The first edge with rst_n = 1 SHALL be frame start (capture per REQ-011); frame_tick and the first outputs SHALL appear on the following edge.
REQ-021 Reset asserted mid-frame SHALL take effect at the next edge regardless of slot or index, with no partial-slot output afterward.

Structure
REQ-022 A shared package/include seg7_pkg SHALL hold AN_OFF (6'h3F), SEG_OFF (8'hFF), the digit-code width (5), and the segment-pattern constants.
REQ-023 Decoding SHALL be a combinational sub-module hex_to_seg (4-bit hex + dp in, 8-bit seg out), reused by other display blocks.

Verification
REQ-024 Bench (DIGIT_CYCLES=4, BLANK_CYCLES=1, 10 ns clock) SHALL cover:
- Reset held 3 clocks, in0..in5 = 5'h10..5'h15 -> an=3F, seg=FF throughout reset; after release, 1 blank cycle, then an=3E, seg=40 (0 with dp) for 3 clocks, then digits 1..5 in order, frame_tick every 24 clocks.
- in0..in5 = 0x0..0x5 applied, in1 changed to 0x8 while digit 3 is displayed -> digit 1 shows 79 for the rest of the frame, 00 from the next frame.
- All 16 hex codes sequenced through in0 across frames -> seg matches the REQ-015 table, seg[7] follows bit4.
- rst_n pulsed low for 1 clock while index = 4 -> next output cycle an=3F, seg=FF; scan restarts at digit 0, shadow recaptured.
- BLANK_CYCLES=0 rebuild -> no all-off cycles, an one-cold every clock; BLANK_CYCLES=4 rebuild -> an stays 3F, frame_tick still every 24 clocks.
- Frame check over 10 frames -> each an bit low exactly 3 clocks per frame, never two anodes low simultaneously.
